adc_spi_reader: RTL and testbench

ADC_SPI_READER -- requirements
Module: adc_spi_reader

---
 rtl/adc_spi_reader.sv | 136 +++++++++++++
 tb/tb_adc_spi_reader.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_spi_reader.sv
// SPI master for a 10-bit serial ADC: runs CS_b/SCLK frames, extracts the data
// field from each frame and flags the end of every WINDOW_SAMPLES-sample window.
module adc_spi_reader #(
  parameter int CLK_DIV        = 4,
  parameter int FRAME_BITS     = 16,
  parameter int LEAD_BITS      = 3,
  parameter int CS_IDLE        = 2,
  parameter int WINDOW_SAMPLES = 1024
) (
  input  logic       clk,
  input  logic       reset_b,
  input  logic       Enable,
  input  logic       MISO,
  output logic       SCLK,
  output logic       CS_b,
  output logic [9:0] SPI_Data,
  output logic       Sample_Valid,
  output logic       Bit_Count_Reached,
  output logic       Busy
);

  localparam int CNT_MAX = (CLK_DIV > CS_IDLE) ? CLK_DIV : CS_IDLE;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int BIT_W   = $clog2(FRAME_BITS + 1);
  localparam int WIN_W   = $clog2(WINDOW_SAMPLES) + 1;

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, GAP} state_t;

  state_t           state;
  logic [CNT_W-1:0] tick_cnt;
  logic [BIT_W-1:0] bit_cnt;
  logic [9:0]       shift_q;
  logic [WIN_W-1:0] win_cnt;

  logic div_done;
  logic gap_done;
  logic in_data_window;
  logic start_frame;

  assign div_done       = (tick_cnt == CNT_W'(CLK_DIV - 1));
  assign gap_done       = (tick_cnt == CNT_W'(CS_IDLE - 1));
  // bit_cnt holds the index of the rising edge about to be produced
  assign in_data_window = (bit_cnt >= BIT_W'(LEAD_BITS)) &&
                          (bit_cnt <  BIT_W'(LEAD_BITS + 10));
  // Enable is only consulted between frames, so dropping it never truncates one
  assign start_frame    = Enable && ((state == IDLE) || (state == GAP && gap_done));

  // NOTE: every register here is written with <= so all updates in a cycle
  // see the same pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state             <= IDLE;
      tick_cnt          <= '0;
      bit_cnt           <= '0;
      shift_q           <= '0;
      win_cnt           <= '0;
      SCLK              <= 1'b0;
      CS_b              <= 1'b1;
      SPI_Data          <= '0;
      Sample_Valid      <= 1'b0;
      Bit_Count_Reached <= 1'b0;
      Busy              <= 1'b0;
    end else begin
      Sample_Valid      <= 1'b0;
      Bit_Count_Reached <= 1'b0;

      if (start_frame) begin
        state    <= SETUP;
        CS_b     <= 1'b0;
        SCLK     <= 1'b0;
        Busy     <= 1'b1;
        tick_cnt <= '0;
        bit_cnt  <= '0;
        shift_q  <= '0;
      end else begin
        case (state)
          IDLE: begin
            Busy <= 1'b0;
          end

          SETUP: begin
            if (div_done) begin
              state    <= SHIFT;
              tick_cnt <= '0;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end

          SHIFT: begin
            if (div_done) begin
              tick_cnt <= '0;
              SCLK     <= ~SCLK;
              if (!SCLK) begin
                bit_cnt <= bit_cnt + 1'b1;
                if (in_data_window) shift_q <= {shift_q[8:0], MISO};
              end else if (bit_cnt == BIT_W'(FRAME_BITS)) begin
                // last falling edge: release the ADC and publish the word
                state        <= GAP;
                CS_b         <= 1'b1;
                SPI_Data     <= shift_q;
                Sample_Valid <= 1'b1;
                if (win_cnt == WIN_W'(WINDOW_SAMPLES - 1)) begin
                  win_cnt           <= '0;
                  Bit_Count_Reached <= 1'b1;
                end else begin
                  win_cnt <= win_cnt + 1'b1;
                end
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end

          GAP: begin
            if (gap_done) begin
              state    <= IDLE;
              Busy     <= 1'b0;
              tick_cnt <= '0;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end

          default: begin
            state <= IDLE;
            CS_b  <= 1'b1;
            SCLK  <= 1'b0;
            Busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_adc_spi_reader.sv
// Directed-plus-random bench for adc_spi_reader: an ADC model serves frames and
// a reference function derives each expected sample from the frame bits.
module tb_adc_spi_reader;

  localparam int CLK_DIV        = 2;
  localparam int FRAME_BITS     = 16;
  localparam int LEAD_BITS      = 3;
  localparam int CS_IDLE        = 2;
  localparam int WINDOW_SAMPLES = 4;
  localparam int CS_LOW_CYC     = CLK_DIV + 2 * CLK_DIV * FRAME_BITS;
  localparam int FRAME_CYC      = CS_LOW_CYC + CS_IDLE;

  logic       clk = 1'b0;
  logic       reset_b = 1'b0;
  logic       Enable = 1'b0;
  logic       MISO = 1'b0;
  logic       SCLK;
  logic       CS_b;
  logic [9:0] SPI_Data;
  logic       Sample_Valid;
  logic       Bit_Count_Reached;
  logic       Busy;

  adc_spi_reader #(
    .CLK_DIV(CLK_DIV), .FRAME_BITS(FRAME_BITS), .LEAD_BITS(LEAD_BITS),
    .CS_IDLE(CS_IDLE), .WINDOW_SAMPLES(WINDOW_SAMPLES)
  ) dut (
    .clk(clk), .reset_b(reset_b), .Enable(Enable), .MISO(MISO),
    .SCLK(SCLK), .CS_b(CS_b), .SPI_Data(SPI_Data), .Sample_Valid(Sample_Valid),
    .Bit_Count_Reached(Bit_Count_Reached), .Busy(Busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Wire bit k of a frame lives at f[FRAME_BITS-1-k]; the sample is wire bits
  // LEAD_BITS..LEAD_BITS+9, first one received being the MSB.
  function automatic logic [9:0] ref_sample(input logic [FRAME_BITS-1:0] f);
    logic [9:0] s = '0;
    for (int k = 0; k < 10; k++) s = {s[8:0], f[FRAME_BITS-1-LEAD_BITS-k]};
    return s;
  endfunction

  function automatic logic [FRAME_BITS-1:0] make_frame(input logic [9:0] d,
                                                       input logic lead, input logic trail);
    logic [FRAME_BITS-1:0] f;
    for (int k = 0; k < FRAME_BITS; k++) begin
      if (k < LEAD_BITS)           f[FRAME_BITS-1-k] = lead;
      else if (k < LEAD_BITS + 10) f[FRAME_BITS-1-k] = d[9-(k-LEAD_BITS)];
      else                         f[FRAME_BITS-1-k] = trail;
    end
    return f;
  endfunction

  // ADC model: a new frame starts on CS_b falling, one bit per SCLK rise
  logic [FRAME_BITS-1:0] frame_q[$];
  logic [9:0]            exp_q[$];
  logic [FRAME_BITS-1:0] cur_frame = '0;
  int                    adc_idx = 0;

  always @(negedge CS_b or posedge SCLK) begin
    if (SCLK) begin
      adc_idx++;
    end else begin
      if (frame_q.size() > 0) cur_frame = frame_q.pop_front();
      else                    cur_frame = FRAME_BITS'($urandom);
      exp_q.push_back(ref_sample(cur_frame));
      adc_idx = 0;
    end
    MISO = (adc_idx < FRAME_BITS) ? cur_frame[FRAME_BITS-1-adc_idx] : 1'b0;
  end

  // Output monitor, sampled on the falling clk edge
  int         cyc = 0;
  int         cs_low = 0;
  int         stray_bcr = 0;
  int         unstable = 0;
  int         sv_cyc[$];
  logic [9:0] sv_dat[$];
  logic       sv_bcr[$];
  logic [9:0] prev_data = '0;

  always @(negedge clk) begin
    cyc++;
    if (!CS_b) cs_low++;
    if (Sample_Valid) begin
      sv_cyc.push_back(cyc);
      sv_dat.push_back(SPI_Data);
      sv_bcr.push_back(Bit_Count_Reached);
    end else if (reset_b && SPI_Data !== prev_data) begin
      unstable++;
    end
    if (Bit_Count_Reached && !Sample_Valid) stray_bcr++;
    prev_data = SPI_Data;
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic clear_mon();
    sv_cyc.delete();
    sv_dat.delete();
    sv_bcr.delete();
    exp_q.delete();
    frame_q.delete();
    cs_low = 0;
  endtask

  task automatic wait_sv(input string tag, input int n, input int budget);
    int b = 0;
    while (sv_cyc.size() < n && b < budget) begin
      step(1);
      b++;
    end
    check({tag, "_sv_timeout"}, sv_cyc.size() >= n, 1);
  endtask

  task automatic wait_bit(input string tag, input int k, input int budget);
    int b = 0;
    while (adc_idx < k && b < budget) begin
      step(1);
      b++;
    end
    check({tag, "_bit_timeout"}, adc_idx >= k, 1);
  endtask

  task automatic run_single(input string tag, input logic [FRAME_BITS-1:0] f,
                            input logic [9:0] exp_data);
    clear_mon();
    frame_q.push_back(f);
    Enable = 1'b1;
    step(1);
    Enable = 1'b0;
    wait_sv(tag, 1, 3 * FRAME_CYC);
    step(CS_IDLE + 2);
    check({tag, "_count"}, sv_cyc.size(), 1);
    check({tag, "_data"}, SPI_Data, exp_data);
    check({tag, "_cs_low"}, cs_low, CS_LOW_CYC);
    check({tag, "_busy"}, Busy, 1'b0);
    check({tag, "_bcr"}, sv_bcr.size() > 0 ? sv_bcr[0] : 1'b1, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_b = 1'b0;
    Enable  = 1'b0;
    step(3);
    check("rst_cs_b", CS_b, 1'b1);
    check("rst_sclk", SCLK, 1'b0);
    check("rst_data", SPI_Data, 10'h000);
    check("rst_sv", Sample_Valid, 1'b0);
    check("rst_bcr", Bit_Count_Reached, 1'b0);
    check("rst_busy", Busy, 1'b0);

    reset_b = 1'b1;
    step(5);
    check("idle_no_enable_busy", Busy, 1'b0);
    check("idle_no_enable_cs", CS_b, 1'b1);

    // Directed frames: 0x2A5 after three zeros, then full ones and full zeros
    run_single("f2a5", make_frame(10'h2A5, 1'b0, 1'b1), 10'h2A5);
    run_single("ones", {FRAME_BITS{1'b1}}, 10'h3FF);
    run_single("zeros", {FRAME_BITS{1'b0}}, 10'h000);

    // Enable dropped at bit 5; this is the 4th sample, so the window closes
    clear_mon();
    Enable = 1'b1;
    step(1);
    wait_bit("drop", 5, 2 * FRAME_CYC);
    Enable = 1'b0;
    wait_sv("drop", 1, 2 * FRAME_CYC);
    step(CS_IDLE + 2);
    check("drop_data", SPI_Data, exp_q.size() > 0 ? exp_q[0] : 10'h000);
    check("drop_cs_low", cs_low, CS_LOW_CYC);
    check("drop_busy", Busy, 1'b0);
    check("drop_cs_b", CS_b, 1'b1);
    check("drop_bcr", sv_bcr.size() > 0 ? sv_bcr[0] : 1'b0, 1'b1);
    step(FRAME_CYC);
    check("drop_no_restart", sv_cyc.size(), 1);

    // Reset pulsed at bit 8 aborts the frame with no sample
    clear_mon();
    Enable = 1'b1;
    step(1);
    wait_bit("abort", 8, 2 * FRAME_CYC);
    reset_b = 1'b0;
    #1;
    check("abort_cs_b", CS_b, 1'b1);
    check("abort_sclk", SCLK, 1'b0);
    check("abort_data", SPI_Data, 10'h000);
    check("abort_busy", Busy, 1'b0);
    Enable = 1'b0;
    step(2);
    reset_b = 1'b1;
    step(4);
    check("abort_no_sv", sv_cyc.size(), 0);
    check("abort_idle", Busy, 1'b0);

    // Back-to-back random frames; window counter restarted by the reset
    clear_mon();
    Enable = 1'b1;
    wait_sv("stream", 12, 13 * FRAME_CYC + 50);
    Enable = 1'b0;
    for (int i = 0; i < 12 && i < sv_dat.size(); i++) begin
      check($sformatf("stream_data%0d", i), sv_dat[i], i < exp_q.size() ? exp_q[i] : 10'h000);
      check($sformatf("stream_bcr%0d", i), sv_bcr[i], (i % WINDOW_SAMPLES) == WINDOW_SAMPLES - 1);
      if (i > 0)
        check($sformatf("stream_period%0d", i), sv_cyc[i] - sv_cyc[i-1], FRAME_CYC);
    end
    begin
      int b = 0;
      while (Busy && b < 2 * FRAME_CYC) begin
        step(1);
        b++;
      end
    end
    check("stream_end_busy", Busy, 1'b0);
    check("stray_bcr", stray_bcr, 0);
    check("data_stable", unstable, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
